// File: rtl/lookahead_up_down_counter.sv
// Registered up/down counter with prefix-AND lookahead step, clamped load, programmable bound,
// wrap pulse and sticky overflow. Define COUNTER_SATURATE_EN to hold at a bound instead of wrapping.
module lookahead_up_down_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_borrow;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_bound;
    logic             w_step;
    logic             w_set_ovf;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;

    // Each bit toggles when every lower bit is 1 (increment) or 0 (decrement).
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_lookahead
            assign w_carry[gi]  = &r_q[gi-1:0];
            assign w_borrow[gi] = &(~r_q[gi-1:0]);
        end
    endgenerate

    assign w_inc = r_q ^ w_carry;
    assign w_dec = r_q ^ w_borrow;

    assign w_at_max   = (r_q == MAX_Q);
    assign w_at_zero  = (r_q == '0);
    assign w_bound    = up ? w_at_max : w_at_zero;
    assign w_step     = en & ~load;
    assign w_set_ovf  = w_step & w_bound;
    assign w_load_val = (d > MAX_Q) ? MAX_Q : d;

    always_comb begin
        w_step_val = up ? w_inc : w_dec;
        if (w_bound) begin
`ifdef COUNTER_SATURATE_EN
            w_step_val = r_q;
`else
            w_step_val = up ? '0 : MAX_Q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (load) begin
                r_q <= w_load_val;
            end else if (en) begin
                r_q <= w_step_val;
            end
            r_wrap <= w_set_ovf;
            // A boundary event in the same cycle as clr_ovf keeps the flag set.
            r_ovf  <= w_set_ovf | (r_ovf & ~clr_ovf);
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_lookahead_up_down_counter.sv
// Bench for lookahead_up_down_counter: 4-bit/MAX 9 and 8-bit/MAX 255 instances vs behavioural model.
module tb_lookahead_up_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: WIDTH=4, MAX_VAL=9
  logic       rst_a = 1'b0, en_a = 1'b0, up_a = 1'b0, load_a = 1'b0, clr_a = 1'b0;
  logic [3:0] d_a = '0;
  logic [3:0] q_a;
  logic       wrap_a, ovf_a;

  // instance B: WIDTH=8, MAX_VAL=255
  logic       rst_b = 1'b0, en_b = 1'b0, up_b = 1'b0, load_b = 1'b0, clr_b = 1'b0;
  logic [7:0] d_b = '0;
  logic [7:0] q_b;
  logic       wrap_b, ovf_b;

  lookahead_up_down_counter #(.WIDTH(4), .MAX_VAL(9)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a), .d(d_a),
    .clr_ovf(clr_a), .q(q_a), .wrap(wrap_a), .ovf(ovf_a)
  );

  lookahead_up_down_counter #(.WIDTH(8), .MAX_VAL(255)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b), .d(d_b),
    .clr_ovf(clr_b), .q(q_b), .wrap(wrap_b), .ovf(ovf_b)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // behavioural reference: integer count and flags derived from the counting rules
  task automatic model_step(inout int mq, inout bit mw, inout bit mo,
                            input bit r, input bit e, input bit u, input bit l,
                            input int dv, input bit c, input int maxv);
    bit hit;
    if (r) begin
      mq = 0; mw = 0; mo = 0;
    end else if (l) begin
      mq = (dv > maxv) ? maxv : dv;
      mw = 0;
      if (c) mo = 0;
    end else if (e) begin
      hit = u ? (mq == maxv) : (mq == 0);
      if (!hit) mq = u ? mq + 1 : mq - 1;
      else begin
`ifdef COUNTER_SATURATE_EN
        mq = mq;
`else
        mq = u ? 0 : maxv;
`endif
      end
      mw = hit;
      if (hit) mo = 1;
      else if (c) mo = 0;
    end else begin
      mw = 0;
      if (c) mo = 0;
    end
  endtask

  int mq_a = 0, mq_b = 0;
  bit mw_a = 0, mo_a = 0, mw_b = 0, mo_b = 0;
  bit ok_a = 0, ok_b = 0;

  always @(posedge clk) begin
    model_step(mq_a, mw_a, mo_a, rst_a, en_a, up_a, load_a, int'(d_a), clr_a, 9);
    if (rst_a) ok_a = 1;
    model_step(mq_b, mw_b, mo_b, rst_b, en_b, up_b, load_b, int'(d_b), clr_b, 255);
    if (rst_b) ok_b = 1;
  end

  // compare process: every cycle once each instance has seen reset
  always @(negedge clk) begin
    if (ok_a) begin
      check("a_q", int'(q_a), mq_a);
      check("a_wrap", int'(wrap_a), int'(mw_a));
      check("a_ovf", int'(ovf_a), int'(mo_a));
    end
    if (ok_b) begin
      check("b_q", int'(q_b), mq_b);
      check("b_wrap", int'(wrap_b), int'(mw_b));
      check("b_ovf", int'(ovf_b), int'(mo_b));
    end
  end

  task automatic cyc_a(input bit r, input bit e, input bit u, input bit l,
                       input logic [3:0] dv, input bit c);
    rst_a = r; en_a = e; up_a = u; load_a = l; d_a = dv; clr_a = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc_b(input bit r, input bit e, input bit u, input bit l,
                       input logic [7:0] dv, input bit c);
    rst_b = r; en_b = e; up_b = u; load_b = l; d_b = dv; clr_b = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  int wraps;

  initial begin
    @(negedge clk);

    // reset and count up through the bound
    cyc_a(1, 0, 0, 0, 4'd0, 0);
    check("lit_rst_q", int'(q_a), 0);
    check("lit_rst_ovf", int'(ovf_a), 0);
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      cyc_a(0, 1, 1, 0, 4'd0, 0);
      wraps += int'(wrap_a);
    end
`ifdef COUNTER_SATURATE_EN
    check("lit_up_q", int'(q_a), 9);
    check("lit_up_wraps", wraps, 3);
`else
    check("lit_up_q", int'(q_a), 2);
    check("lit_up_wraps", wraps, 1);
`endif
    check("lit_up_ovf", int'(ovf_a), 1);

    // clamped load then count down through zero
    cyc_a(0, 0, 0, 1, 4'hF, 0);
    check("lit_clamp_q", int'(q_a), 9);
    check("lit_clamp_wrap", int'(wrap_a), 0);
    wraps = 0;
    for (int i = 0; i < 11; i++) begin
      cyc_a(0, 1, 0, 0, 4'd0, 0);
      wraps += int'(wrap_a);
    end
`ifdef COUNTER_SATURATE_EN
    check("lit_dn_q", int'(q_a), 0);
    check("lit_dn_wraps", wraps, 2);
`else
    check("lit_dn_q", int'(q_a), 8);
    check("lit_dn_wraps", wraps, 1);
`endif

    // set wins over clr_ovf, then clear
    cyc_a(0, 0, 0, 1, 4'd9, 1);
    cyc_a(0, 1, 1, 0, 4'd0, 1);
`ifdef COUNTER_SATURATE_EN
    check("lit_setclr_q", int'(q_a), 9);
`else
    check("lit_setclr_q", int'(q_a), 0);
`endif
    check("lit_setclr_wrap", int'(wrap_a), 1);
    check("lit_setclr_ovf", int'(ovf_a), 1);
    cyc_a(0, 0, 0, 0, 4'd0, 1);
    check("lit_clr_ovf", int'(ovf_a), 0);

    // load priority over enable, then reset overrides enable
    cyc_a(0, 0, 0, 1, 4'd5, 0);
    cyc_a(0, 1, 1, 1, 4'd2, 0);
    check("lit_loadpri_q", int'(q_a), 2);
    check("lit_loadpri_wrap", int'(wrap_a), 0);
    cyc_a(0, 1, 1, 0, 4'd0, 0);
    cyc_a(1, 1, 1, 0, 4'd0, 0);
    check("lit_rst2_q", int'(q_a), 0);
    check("lit_rst2_wrap", int'(wrap_a), 0);
    check("lit_rst2_ovf", int'(ovf_a), 0);

    // randomized traffic on A
    for (int i = 0; i < 2000; i++) begin
      cyc_a(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
            ($urandom_range(7) == 0), 4'($urandom), ($urandom_range(7) == 0));
    end

    // 8-bit full carry chain
    cyc_b(1, 0, 0, 0, 8'd0, 0);
    cyc_b(0, 0, 0, 1, 8'hFF, 0);
    cyc_b(0, 1, 1, 0, 8'd0, 0);
`ifdef COUNTER_SATURATE_EN
    check("lit_b_ff_q", int'(q_b), 255);
`else
    check("lit_b_ff_q", int'(q_b), 0);
`endif
    check("lit_b_ff_wrap", int'(wrap_b), 1);
    cyc_b(0, 0, 0, 1, 8'h7F, 0);
    cyc_b(0, 1, 1, 0, 8'd0, 0);
    check("lit_b_7f_q", int'(q_b), 128);
    check("lit_b_7f_wrap", int'(wrap_b), 0);
    cyc_b(0, 0, 0, 1, 8'h80, 0);
    cyc_b(0, 1, 0, 0, 8'd0, 0);
    check("lit_b_80dn_q", int'(q_b), 127);

    for (int i = 0; i < 400; i++) begin
      cyc_b(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
            ($urandom_range(15) == 0), 8'($urandom), ($urandom_range(7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
